gaussian_blur_stage: RTL

- Second stage of the Canny pipeline, directly downstream of grayscale_top.
- Consumes 8-bit grayscale pixels from grayscale_top's output FIFO (empty/rd_en/dout) in raster order.
- Applies the 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16.
- Writes one 8-bit blurred pixel per input pixel into the next FIFO (full/wr_en/din), which feeds the Sobel stage.

---
 rtl/canny_pkg.sv | 20 ++
 rtl/line_buffer.sv | 31 +++
 rtl/gaussian_blur_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline.
// Stage FSM encoding and Gaussian kernel constants.
package canny_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } blur_state_t;

    localparam int SUM_W = 12;
    localparam int SHIFT = 4;

    localparam logic [SUM_W-1:0] KERNEL [3][3] = '{
        '{12'd1, 12'd2, 12'd1},
        '{12'd2, 12'd4, 12'd2},
        '{12'd1, 12'd2, 12'd1}
    };

endpackage

// File: rtl/line_buffer.sv
// Shift-enabled delay line of DEPTH entries.
// The tap presents the entry written DEPTH steps ago.
module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] tap
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Delay line storage: clear on reset or frame end, shift when enabled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= d;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign tap = mem[DEPTH-1];

endmodule

// File: rtl/gaussian_blur_stage.sv
// 3x3 Gaussian blur between two FIFOs, one pixel per cycle.
// Output lags input by WIDTH+1 pixels; a flush drains the tail.
module gaussian_blur_stage
    import canny_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_empty,
    output logic       in_rd_en,
    input  logic [7:0] in_dout,
    input  logic       out_full,
    output logic       out_wr_en,
    output logic [7:0] out_din
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int IN_W  = $clog2(NPIX);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(NPIX - 1);
    localparam logic [IN_W-1:0]  FILL_END = IN_W'(WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    blur_state_t state, state_nx;
    logic step, frame_end, flush_done;
    logic [IN_W-1:0]  in_cnt;
    logic [COL_W-1:0] out_col;
    logic [ROW_W-1:0] out_row;
    logic [7:0] p, lb0_tap, lb1_tap;
    logic [7:0] win_l [3];
    logic [7:0] win_m [3];
    logic [7:0] col_new [3];
    logic [SUM_W-1:0] sum;
    logic border;

    assign frame_end  = (out_row == ROW_LAST) && (out_col == COL_LAST);
    assign flush_done = step && (state == S_FLUSH) && frame_end;
    assign p          = (state == S_FLUSH) ? 8'd0 : in_dout;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_FILL;
        else          state <= state_nx;
    end

    // Next state: prime WIDTH+1 pixels, stream, then drain the tail
    always_comb begin
        state_nx = state;
        unique case (state)
            S_FILL:  if (step && in_cnt == FILL_END) state_nx = S_RUN;
            S_RUN:   if (step && in_cnt == IN_LAST)  state_nx = S_FLUSH;
            S_FLUSH: if (flush_done)                 state_nx = S_FILL;
            default: state_nx = S_FILL;
        endcase
    end

    // Handshake outputs: a step needs every FIFO this state touches
    always_comb begin
        step = 1'b0;
        unique case (state)
            S_FILL:  step = ~in_empty;
            S_RUN:   step = ~in_empty & ~out_full;
            S_FLUSH: step = ~out_full;
            default: step = 1'b0;
        endcase
        in_rd_en  = reset_n & step & (state != S_FLUSH);
        out_wr_en = reset_n & step & (state != S_FILL);
    end

    // Input and output position counters, all wrapping at frame end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt  <= '0;
            out_col <= '0;
            out_row <= '0;
        end else begin
            if (in_rd_en)
                in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + IN_W'(1);
            if (out_wr_en) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end
        end
    end

    line_buffer #(.DEPTH(WIDTH), .DATA_W(8)) u_lb0 (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (step),
        .clr     (flush_done),
        .d       (p),
        .tap     (lb0_tap)
    );

    line_buffer #(.DEPTH(WIDTH), .DATA_W(8)) u_lb1 (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (step),
        .clr     (flush_done),
        .d       (lb0_tap),
        .tap     (lb1_tap)
    );

    assign col_new[0] = lb1_tap;
    assign col_new[1] = lb0_tap;
    assign col_new[2] = p;

    // Window columns: the two previous columns; the newest is combinational
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_l <= '{default: '0};
            win_m <= '{default: '0};
        end else if (flush_done) begin
            win_l <= '{default: '0};
            win_m <= '{default: '0};
        end else if (step) begin
            win_l <= win_m;
            win_m <= col_new;
        end
    end

    // Weighted sum around the centre pixel, zeroed on the frame border
    always_comb begin
        sum = '0;
        for (int r = 0; r < 3; r++) begin
            sum = sum + KERNEL[r][0] * SUM_W'(win_l[r])
                      + KERNEL[r][1] * SUM_W'(win_m[r])
                      + KERNEL[r][2] * SUM_W'(col_new[r]);
        end
        border = (out_row == '0) || (out_row == ROW_LAST) ||
                 (out_col == '0) || (out_col == COL_LAST);
        out_din = (!reset_n || border) ? 8'd0 : sum[SUM_W-1:SHIFT];
    end

endmodule
